// File: rtl/rgb_column_packer_if.sv
// Pixel-FIFO read side and column-FIFO write side of rgb_column_packer.
// The master modport is the packer; the slave modport is the surrounding FIFOs.
interface rgb_column_packer_if #(
  parameter int PIXEL_DWIDTH = 24
);
  logic [PIXEL_DWIDTH-1:0]   in_dout;
  logic                      in_empty;
  logic                      in_rd_en;
  logic [3*PIXEL_DWIDTH-1:0] out_din;
  logic                      out_full;
  logic                      out_wr_en;

  modport master (
    input  in_dout, in_empty, out_full,
    output in_rd_en, out_din, out_wr_en
  );

  modport slave (
    output in_dout, in_empty, out_full,
    input  in_rd_en, out_din, out_wr_en
  );
endinterface

// File: rtl/rgb_column_packer.sv
// Packs a raster RGB pixel stream into {row r+2, row r+1, row r} columns.
// Define RGB_COLUMN_PACKER_AUTO_RESTART_EN to pulse frame_done and restart per frame.
//
// state  | meaning
// FILL   | rows 0 and 1 go into the line buffers only
// STREAM | every pop registers one 3-row column
// DRAIN  | no pops; waiting for the last column to be written
// DONE   | frame complete; sticky, or one cycle with auto restart
module rgb_column_packer #(
  parameter int WIDTH        = 720,
  parameter int HEIGHT       = 540,
  parameter int PIXEL_DWIDTH = 24
) (
  input  logic                 clock,
  input  logic                 reset,
  rgb_column_packer_if.master  bus,
  output logic                 frame_done
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  typedef enum logic [1:0] {FILL, STREAM, DRAIN, DONE} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             col_q, col_d;
  logic [RW-1:0]             row_q, row_d;
  logic                      out_valid_q, out_valid_d;
  logic [3*PIXEL_DWIDTH-1:0] out_din_q, out_din_d;
  logic                      frame_done_q, frame_done_d;

  logic [PIXEL_DWIDTH-1:0]   lb0_q [WIDTH];
  logic [PIXEL_DWIDTH-1:0]   lb1_q [WIDTH];

  logic pop;
  logic wr;
  logic col_last;

  assign col_last = (col_q == COL_LAST);
  // Write gated by reset so a pending column is dropped, not flushed.
  assign wr  = out_valid_q && !bus.out_full && !reset;
  assign pop = !bus.in_empty && !reset &&
               ((state_q == FILL) ||
                ((state_q == STREAM) && (!out_valid_q || !bus.out_full)));

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    out_valid_d  = out_valid_q && !wr;
    out_din_d    = out_din_q;
    frame_done_d = frame_done_q;

    if (pop) begin
      if (col_last) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    case (state_q)
      FILL: begin
        if (pop && (row_q == ROW_ONE) && col_last) state_d = STREAM;
      end
      STREAM: begin
        if (pop) begin
          out_din_d   = {bus.in_dout, lb1_q[col_q], lb0_q[col_q]};
          out_valid_d = 1'b1;
          if ((row_q == ROW_LAST) && col_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!out_valid_d) begin
          state_d      = DONE;
          frame_done_d = 1'b1;
        end
      end
      DONE: begin
`ifdef RGB_COLUMN_PACKER_AUTO_RESTART_EN
        state_d      = FILL;
        frame_done_d = 1'b0;
        col_d        = '0;
        row_d        = '0;
`else
        frame_done_d = 1'b1;
`endif
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= FILL;
      col_q        <= '0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      out_din_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      out_valid_q  <= out_valid_d;
      out_din_q    <= out_din_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffers keep their contents through reset; FILL rewrites them anyway.
  always_ff @(posedge clock) begin
    if (pop) begin
      lb0_q[col_q] <= lb1_q[col_q];
      lb1_q[col_q] <= bus.in_dout;
    end
  end

  assign bus.in_rd_en  = pop;
  assign bus.out_wr_en = wr;
  assign bus.out_din   = out_din_q;
  assign frame_done    = frame_done_q;
endmodule

// File: doc/rgb_column_packer.md
# rgb_column_packer

Converts a single raster-order RGB pixel stream into the 3-row column stream consumed by the RGB input FIFO of `dut_system`, producing in hardware the `{row r+2, row r+1, row r}` packing that the bench currently builds from three file offsets. Two WIDTH-deep line buffers hold the previous two rows. Each incoming pixel of row 2 onward emits one 72-bit column. The block sits between an upstream 24-bit pixel FIFO (read side) and the `fifo_rgb` write interface.

## Interface
Parameters:
- `WIDTH`, 720, pixels per row
- `HEIGHT`, 540, rows per frame
- `PIXEL_DWIDTH`, 24, bits per RGB pixel; output width is 3*PIXEL_DWIDTH

Ports:
- `clock`  in  1  single clock; all logic is on the rising edge
- `reset`  in  1  synchronous, active-high
- `in_dout`  in  PIXEL_DWIDTH  upstream FIFO head; first-word-fall-through, valid when `in_empty`=0
- `in_empty`  in  1  upstream FIFO empty
- `in_rd_en`  out  1  pops the upstream head this cycle
- `out_din`  out  3*PIXEL_DWIDTH  column word: [PD-1:0] = row r, [2PD-1:PD] = row r+1, [3PD-1:2PD] = row r+2
- `out_full`  in  1  downstream FIFO full
- `out_wr_en`  out  1  writes `out_din` this cycle
- `frame_done`  out  1  frame-complete indication (see Configuration)

## Operation
- Counters: `col` runs 0..WIDTH-1 and `row` runs 0..HEIGHT-1. Both are $clog2 width and advance on every pop. `col` wraps to 0 at WIDTH-1, which increments `row`.
- Line buffers `lb0` and `lb1` each hold WIDTH entries of PIXEL_DWIDTH bits, with combinational read at `col`. On every pop: `lb0[col] <= lb1[col]` and `lb1[col] <= in_dout`.
- FSM states:
  - FILL: active while `row` < 2. Pops are stored only; no output. Goes to STREAM on the pop of pixel (1, WIDTH-1).
  - STREAM: each pop loads the output register with `{in_dout, lb1[col], lb0[col]}` and sets `out_valid`. On the pop of pixel (HEIGHT-1, WIDTH-1), goes to DRAIN.
  - DRAIN: no pops. Goes to DONE once `out_valid` is 0.
  - DONE: no pops and no writes. Exit behaviour is set by the macro (see Configuration).
- `in_rd_en` is combinational: `!in_empty && !reset && (state==FILL || (state==STREAM && (!out_valid || !out_full)))`.
- `out_wr_en` = `out_valid && !out_full`. The output register clears `out_valid` on a write unless it is reloaded in the same cycle.
- A write and a pop in the same cycle are legal, giving sustained throughput of 1 column/cycle.
- Columns per frame = (HEIGHT-2)*WIDTH. The first column is x=0 of rows 0/1/2.
- Boundaries:
  - `in_empty`=1: stall, with no counter movement.
  - `out_full`=1 while `out_valid`=1: hold `out_din` stable and do not pop.
  - Row wrap: `col` returns to 0 with no bubble.

## Timing
- Reset values:
  - `in_rd_en`=0, `out_wr_en`=0, `out_din`=0, `frame_done`=0
  - state=FILL, `col`=`row`=0, `out_valid`=0
  - Line-buffer contents are not cleared.
- Latency: a pop in cycle N makes `out_wr_en` assert in cycle N+1 if `out_full`=0.
- `out_din` changes only on a reload; it is stable while `out_valid`=1 and `out_full`=1.
- Reset mid-frame:
  - Takes effect at the next edge. The partial frame is discarded and any pending column is dropped.
  - `in_rd_en` is forced to 0 while `reset`=1.
  - The next frame restarts at FILL.
- `out_full` and `in_empty` are sampled combinationally each cycle. No registered full look-ahead is used.

## Configuration
- `RGB_COLUMN_PACKER_AUTO_RESTART_EN` defined:
  - DONE lasts one cycle with `frame_done`=1 (a pulse), then returns to FILL with counters at 0.
  - Back-to-back frames need no reset.
- Not defined:
  - DONE is sticky and `frame_done` is a level held at 1 until `reset`.
  - Further input remains unread.

## Test plan
All scenarios use WIDTH=4, HEIGHT=4, PIXEL_DWIDTH=24, and pixel(r,x)=24'h00_rr_xx.
- Full frame with the input always available and `out_full`=0:
  - First write: `out_din`={24'h000200, 24'h000100, 24'h000000}.
  - Exactly 8 writes. The last is {24'h000303, 24'h000203, 24'h000103}.
  - `frame_done` rises 2 cycles after the final pop.
- `out_full` held at 1 for 5 cycles after the first column is registered:
  - `out_din` is held constant and `in_rd_en`=0 throughout.
  - On release, the write resumes with no lost or duplicate columns (8 total).
- `in_empty` toggled every other cycle:
  - The column sequence is identical to scenario 1.
  - `col` and `row` never advance on empty cycles.
- `reset` asserted for 1 cycle after 3 writes, then a fresh frame is sent:
  - Outputs are 0 one cycle after reset.
  - The next 8 writes match scenario 1 exactly.
- Two frames back-to-back:
  - With the macro: 16 writes and two 1-cycle `frame_done` pulses.
  - Without the macro: 8 writes, `frame_done` held at 1, and `in_rd_en`=0 for the second frame.
- Row wrap check: the cycle after the pop of pixel (2,3), the pop of pixel (3,0) yields {24'h000300, 24'h000200, 24'h000100}, with no idle cycle in between.
